// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and small types used by the timing
// generator and the game objects that consume its outputs.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int SCREEN_W = H_ACTIVE;
    localparam int SCREEN_H = V_ACTIVE;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] coord_t;

    // Registered per-pixel decodes, kept together so reset and hold are uniform.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic frame_start;
        logic move;
    } vga_ctrl_t;

    localparam vga_ctrl_t CTRL_RST = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b0,
                                       frame_start: 1'b1, move: 1'b0};

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator drives it, consumers sample it on pixpulse.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic   pause;
    logic   pixpulse;
    coord_t hcount;
    coord_t vcount;
    logic   hsync;
    logic   vsync;
    logic   blank;
    logic   frame_start;
    logic   move;

    modport master (
        input  pause,
        output pixpulse, hcount, vcount, hsync, vsync, blank, frame_start, move
    );

    modport slave (
        output pause,
        input  pixpulse, hcount, vcount, hsync, vsync, blank, frame_start, move
    );
endinterface

// File: rtl/pix_strobe_gen.sv
// Clock divider producing a one-clock pixel-rate enable every CLK_DIV clocks.
module pix_strobe_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pixpulse_o
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == LAST) div_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    // With CLK_DIV=1 the divider is stuck at 0 == LAST, so the strobe stays high.
    assign pixpulse_o = (div_q == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel strobe, h/v counters, sync/blank decodes,
// frame_start and the per-frame move strobe at the start of vertical blank.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int MOVE_DIV = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    vga_timing_gen_if.master        tim_if
);
    import vga_pkg::*;

    localparam int H_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_LEN - 1);
    localparam coord_t V_LAST   = coord_t'(V_LEN - 1);
    localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [7:0] FRAME_LAST = 8'(MOVE_DIV - 1);

    logic       pix;
    coord_t     hcount_q, hcount_d;
    coord_t     vcount_q, vcount_d;
    logic [7:0] frame_q, frame_d;
    vga_ctrl_t  ctrl_q, ctrl_d;

    pix_strobe_gen #(.CLK_DIV(CLK_DIV)) u_strobe (
        .clk        (clk),
        .rst        (rst),
        .pixpulse_o (pix)
    );

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        frame_d  = frame_q;
        ctrl_d   = ctrl_q;

        if (pix) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d = '0;
                    frame_d  = (frame_q == FRAME_LAST) ? 8'd0 : frame_q + 8'd1;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end

            // Decodes look at the next counts so they line up with the pixel being loaded.
            ctrl_d.hsync       = !in_window(hcount_d, HS_FIRST, HS_LAST);
            ctrl_d.vsync       = !in_window(vcount_d, VS_FIRST, VS_LAST);
            ctrl_d.blank       = (hcount_d >= H_VIS) || (vcount_d >= V_VIS);
            ctrl_d.frame_start = (hcount_d == '0) && (vcount_d == '0);
            // pause is only looked at here, so mid-strobe toggles cannot reshape move.
            ctrl_d.move        = (hcount_d == '0) && (vcount_d == V_VIS) &&
                                 (frame_q == FRAME_LAST) && !tim_if.pause;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            frame_q  <= '0;
            ctrl_q   <= CTRL_RST;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            frame_q  <= frame_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign tim_if.pixpulse    = pix;
    assign tim_if.hcount      = hcount_q;
    assign tim_if.vcount      = vcount_q;
    assign tim_if.hsync       = ctrl_q.hsync;
    assign tim_if.vsync       = ctrl_q.vsync;
    assign tim_if.blank       = ctrl_q.blank;
    assign tim_if.frame_start = ctrl_q.frame_start;
    assign tim_if.move        = ctrl_q.move;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Three generators (full 640x480, a shrunken raster with MOVE_DIV=3, and a
// CLK_DIV=1 shrunken raster) compared every clock against a clock-count model.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 3;
    localparam int S_VA = 8,  S_VFP = 2, S_VS = 2, S_VBP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_sm ();
    vga_timing_gen_if if_c1 ();

    vga_timing_gen u_def (.clk(clk), .rst(rst), .tim_if(if_def));

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .MOVE_DIV(3)
    ) u_sm (.clk(clk), .rst(rst), .tim_if(if_sm));

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .MOVE_DIV(1)
    ) u_c1 (.clk(clk), .rst(rst), .tim_if(if_c1));

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n      = 0;      // clock edges since the last reset edge
    logic mvp [3];         // pause seen when the current pixel was loaded

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp, n);
    endtask

    // Reference: pixel index is simply edges/CLK_DIV; everything else is arithmetic on it.
    task automatic check_dut(
        input string pfx, input int id, input int cd,
        input int ha, input int hfp, input int hsw, input int hbp,
        input int va, input int vfp, input int vsw, input int vbp, input int md,
        input logic pz, input logic pp, input logic [9:0] hc, input logic [9:0] vc,
        input logic hs, input logic vs, input logic bl, input logic fs, input logic mv);
        int ht, vt, p, ehc, evc, frm;
        ht  = ha + hfp + hsw + hbp;
        vt  = va + vfp + vsw + vbp;
        p   = n / cd;
        ehc = p % ht;
        evc = (p / ht) % vt;
        frm = p / (ht * vt);
        if (n > 0 && (n % cd) == 0) mvp[id] = pz;
        chk({pfx, ".pixpulse"}, 32'(pp), 32'((n % cd) == cd - 1));
        chk({pfx, ".hcount"},   32'(hc), 32'(ehc));
        chk({pfx, ".vcount"},   32'(vc), 32'(evc));
        chk({pfx, ".hsync"},    32'(hs), 32'(!(ehc >= ha + hfp && ehc < ha + hfp + hsw)));
        chk({pfx, ".vsync"},    32'(vs), 32'(!(evc >= va + vfp && evc < va + vfp + vsw)));
        chk({pfx, ".blank"},    32'(bl), 32'(ehc >= ha || evc >= va));
        chk({pfx, ".frame_start"}, 32'(fs), 32'(ehc == 0 && evc == 0));
        chk({pfx, ".move"},     32'(mv),
            32'(n > 0 && ehc == 0 && evc == va && (frm % md) == md - 1 && !mvp[id]));
    endtask

    task automatic check_all(input logic pz0, input logic pz1, input logic pz2);
        check_dut("def", 0, 4, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP, 1,
                  pz0, if_def.pixpulse, if_def.hcount, if_def.vcount, if_def.hsync,
                  if_def.vsync, if_def.blank, if_def.frame_start, if_def.move);
        check_dut("sm", 1, 4, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 3,
                  pz1, if_sm.pixpulse, if_sm.hcount, if_sm.vcount, if_sm.hsync,
                  if_sm.vsync, if_sm.blank, if_sm.frame_start, if_sm.move);
        check_dut("c1", 2, 1, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1,
                  pz2, if_c1.pixpulse, if_c1.hcount, if_c1.vcount, if_c1.hsync,
                  if_c1.vsync, if_c1.blank, if_c1.frame_start, if_c1.move);
    endtask

    task automatic run_cycle();
        logic pz0, pz1, pz2;
        pz0 = if_def.pause;
        pz1 = if_sm.pause;
        pz2 = if_c1.pause;
        @(posedge clk);
        if (rst) n = 0;
        else     n++;
        #1;
        check_all(pz0, pz1, pz2);
        if_def.pause = ($urandom_range(0, 3) == 0);
        if_sm.pause  = ($urandom_range(0, 3) == 0);
        if_c1.pause  = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) mvp[i] = 1'b0;
        if_def.pause = 1'b0;
        if_sm.pause  = 1'b0;
        if_c1.pause  = 1'b0;
        rst = 1'b1;
        repeat (3) run_cycle();

        rst = 1'b0;
        for (int k = 0; k < 9000; k++) run_cycle();

        // Mid-frame reset: one edge must restore every register, reset beating pixpulse.
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        for (int k = 0; k < 2000; k++) run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
